uart_mem_loader: RTL

- Sits directly upstream of dmemory32 and drives its address, write-data and write-enable inputs.
- In normal mode it passes the CPU's data-memory request through unchanged.
- When a load is started, it takes over the memory port. It assembles received UART bytes into 32-bit words and writes them to consecutive word addresses from 0.
- The load ends on a word-count limit or an idle timeout, after which CPU control is restored.

---
 rtl/uart_mem_loader_pkg.sv | 12 +
 rtl/uart_mem_loader_word_packer.sv | 40 ++++
 rtl/uart_mem_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: shared state encoding and word geometry for the UART memory loader
// Contents: loaderState_t (IDLE/COLLECT/WRITE/DONE), DATA_WIDTH, BYTES_PER_WORD
package uart_mem_loader_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loaderState_t;
    localparam int DATA_WIDTH     = 32;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_mem_loader_word_packer.sv
// uart_mem_loader_word_packer: assembles little-endian bytes into a word, with a zero-padded flush view
// Ports: clock, resetn (async active-low), clear (drop partial word), accept (byte taken),
//        byteIn, byteCount (bytes held), lastByte (accept completes a word),
//        fullWord (word including the byte being accepted), padWord (held bytes, upper bytes zeroed)
module uart_mem_loader_word_packer
    import uart_mem_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byteIn,
    output logic [1:0]            byteCount,
    output logic                  lastByte,
    output logic [DATA_WIDTH-1:0] fullWord,
    output logic [DATA_WIDTH-1:0] padWord
);
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [5:0]            padShift;

    // New bytes enter at the top, so after four bytes the first one sits in [7:0].
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shiftReg  <= '0;
            byteCount <= '0;
        end else if (clear) begin
            shiftReg  <= '0;
            byteCount <= '0;
        end else if (accept) begin
            shiftReg  <= fullWord;
            byteCount <= byteCount + 2'd1;
        end
    end

    assign fullWord = {byteIn, shiftReg[DATA_WIDTH-1:8]};
    assign lastByte = accept && byteCount == 2'(BYTES_PER_WORD - 1);
    // A partial word lives in the top bytes; shifting it down leaves zeros above it.
    assign padShift = {3'(BYTES_PER_WORD) - {1'b0, byteCount}, 3'b000};
    assign padWord  = shiftReg >> padShift;
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: loads UART bytes as 32-bit words into data memory, otherwise passes CPU accesses through
// Ports: clock, resetn (async active-low), start (load pulse);
//        rx_valid/rx_data/rx_ready (byte stream in);
//        cpu_addr/cpu_write_data/cpu_mem_write (CPU request);
//        mem_addr/mem_write_data/mem_write (to dmemory32);
//        busy (loader owns port), done (last load finished), words_loaded (words written)
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int MAX_WORDS      = 16384,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_write_data,
    input  logic                  cpu_mem_write,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int                    IDLE_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_WIDTH-1:0] IDLE_LAST  = IDLE_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0]   LAST_ADDR  = (ADDR_WIDTH + 1)'(MAX_WORDS - 1);

    loaderState_t          state;
    logic [ADDR_WIDTH:0]   wordAddr;
    logic [IDLE_WIDTH-1:0] idleCount;
    logic [DATA_WIDTH-1:0] memWord;
    logic                  finalWrite;
    logic                  accept;
    logic                  timeoutHit;
    logic                  packerClear;
    logic [1:0]            byteCount;
    logic                  lastByte;
    logic [DATA_WIDTH-1:0] fullWord;
    logic [DATA_WIDTH-1:0] padWord;

    assign accept      = state == COLLECT && rx_valid;
    // A byte arriving on the timeout cycle wins, so timeout requires an empty cycle.
    assign timeoutHit  = state == COLLECT && !rx_valid && idleCount == IDLE_LAST;
    assign packerClear = ((state == IDLE || state == DONE) && start) || timeoutHit;

    uart_mem_loader_word_packer wordPacker (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (packerClear),
        .accept    (accept),
        .byteIn    (rx_data),
        .byteCount (byteCount),
        .lastByte  (lastByte),
        .fullWord  (fullWord),
        .padWord   (padWord)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            wordAddr   <= '0;
            idleCount  <= '0;
            memWord    <= '0;
            finalWrite <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= COLLECT;
                    wordAddr  <= '0;
                    idleCount <= '0;
                    done      <= 1'b0;
                end
                COLLECT: if (rx_valid) begin
                    idleCount <= '0;
                    if (lastByte) begin
                        memWord    <= fullWord;
                        finalWrite <= 1'b0;
                        state      <= WRITE;
                    end
                end else if (timeoutHit) begin
                    idleCount <= '0;
                    if (byteCount != 2'd0) begin
                        memWord    <= padWord;
                        finalWrite <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end else begin
                    idleCount <= idleCount + IDLE_WIDTH'(1);
                end
                WRITE: begin
                    wordAddr  <= wordAddr + (ADDR_WIDTH + 1)'(1);
                    idleCount <= '0;
                    if (finalWrite || wordAddr == LAST_ADDR) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // While busy the CPU store strobe is dropped and reads see the loader's address.
    assign busy           = state == COLLECT || state == WRITE;
    assign rx_ready       = state == COLLECT;
    assign mem_addr       = busy ? 32'({wordAddr, 2'b00}) : cpu_addr;
    assign mem_write_data = busy ? memWord : cpu_write_data;
    assign mem_write      = busy ? state == WRITE : cpu_mem_write;
    assign words_loaded   = wordAddr;
endmodule
